// File: rtl/mixer_ser_pkg.sv
// Shared types, defaults and frame-length helper for mixer_sample_serializer.
// Build option: SERIALIZER_PARITY_EN appends one even-parity bit to every frame.
package mixer_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_CLK_DIV    = 4;

    // Bits per serial frame, including the optional parity bit.
    function automatic int unsigned calc_nbits(input int unsigned data_w);
`ifdef SERIALIZER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/mixer_ser_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/level derive only from the pointer flops.
module mixer_ser_fifo
    import mixer_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mixer_sample_serializer.sv
// Buffers mixer samples and ships them MSB-first as SPI-mode-0 frames on sclk/sdo/cs_n.
// Build option: SERIALIZER_PARITY_EN adds an even-parity bit after the LSB.
module mixer_sample_serializer
    import mixer_ser_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          enable_i,
    input  logic                          s_valid_i,
    input  logic [DATA_W-1:0]             s_data_i,
    output logic                          s_ready_o,
    input  logic                          clr_ovf_i,
    output logic                          ser_sclk_o,
    output logic                          ser_sdo_o,
    output logic                          ser_cs_n_o,
    output logic [2:0]                    ser_oeb_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);

    localparam int unsigned NBITS = calc_nbits(DATA_W);
    localparam int unsigned BCW   = $clog2(NBITS);
    localparam int unsigned DCW   = $clog2(2 * CLK_DIV);

    ser_state_e        state;
    logic [NBITS-1:0]  shreg;
    logic [NBITS-1:0]  frame;
    logic [BCW-1:0]    bit_cnt;
    logic [DCW-1:0]    div_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign push      = s_valid_i && !full;
    assign pop       = (state == ST_IDLE) && enable_i && !empty;
    assign s_ready_o = !full;
    assign ser_oeb_o = 3'b000;

`ifdef SERIALIZER_PARITY_EN
    assign frame = {head, ^head};
`else
    assign frame = head;
`endif

    mixer_ser_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .push      (push),
        .push_data (s_data_i),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level_o)
    );

    // Set wins over a coincident clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            overflow_o <= 1'b0;
        end else if (s_valid_i && full) begin
            overflow_o <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
        end
    end

    // Frame FSM; pins are registered, so each branch sets what the next cycle shows.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ser_cs_n_o <= 1'b1;
            ser_sclk_o <= 1'b0;
            ser_sdo_o  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shreg      <= frame;
                        bit_cnt    <= BCW'(NBITS - 1);
                        div_cnt    <= '0;
                        state      <= ST_SHIFT;
                        ser_cs_n_o <= 1'b0;
                        ser_sclk_o <= 1'b0;
                        ser_sdo_o  <= frame[NBITS-1];
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DCW'(2 * CLK_DIV - 1)) begin
                        div_cnt    <= '0;
                        ser_sclk_o <= 1'b0;
                        if (bit_cnt == '0) begin
                            state      <= ST_GAP;
                            ser_cs_n_o <= 1'b1;
                            ser_sdo_o  <= 1'b0;
                        end else begin
                            shreg     <= shreg << 1;
                            ser_sdo_o <= shreg[NBITS-2];
                            bit_cnt   <= bit_cnt - BCW'(1);
                        end
                    end else begin
                        div_cnt    <= div_cnt + DCW'(1);
                        ser_sclk_o <= ((div_cnt + DCW'(1)) >= DCW'(CLK_DIV));
                    end
                end
                ST_GAP: begin
                    if (div_cnt == DCW'(2 * CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
